// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter with jump, relative branch, call/return and
//               a LIFO return-address stack with sticky overflow/underflow
//               error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int AW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       CLEAR,
  input  logic                       PC_ENABLE,
  input  logic                       JMP_SGNL,
  input  logic                       BR_REL,
  input  logic                       CALL,
  input  logic                       RET,
  input  logic [AW-1:0]              ADDRESS,
  output logic [AW-1:0]              pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       STACK_FULL,
  output logic                       STACK_EMPTY,
  output logic                       STACK_ERR
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic          push_d;

  // Return-address storage; validity is tracked solely by depth_q.
  logic [AW-1:0] stack_q [DEPTH];

  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [AW-1:0] pc_inc;
  logic          full;
  logic          empty;

  assign full   = (depth_q == DW'(DEPTH));
  assign empty  = (depth_q == '0);
  assign wr_idx = depth_q[IW-1:0];
  assign rd_idx = IW'(depth_q - DW'(1));
  assign pc_inc = pc_q + AW'(1);

  // Next-state selection: RET > CALL > JMP > BR > increment, all gated by enable.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push_d  = 1'b0;
    if (PC_ENABLE) begin
      if (RET) begin
        // A simultaneous CALL is silently dropped.
        if (!empty) begin
          pc_d    = stack_q[rd_idx];
          depth_d = depth_q - DW'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (CALL) begin
        if (!full) begin
          push_d  = 1'b1;
          depth_d = depth_q + DW'(1);
          pc_d    = ADDRESS;
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (JMP_SGNL) begin
        pc_d = ADDRESS;
      end else if (BR_REL) begin
        // Two's-complement offset: plain modulo-2^AW addition.
        pc_d = pc_q + ADDRESS;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Control state registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (CLEAR) begin
      pc_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack write on a successful push; storage itself is never cleared.
  always_ff @(posedge clock) begin
    if (push_d && !CLEAR) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign depth       = depth_q;
  assign STACK_FULL  = full;
  assign STACK_EMPTY = empty;
  assign STACK_ERR   = err_q;

endmodule
`default_nettype wire
